msg_fifo_sc: RTL and testbench
==============================

# msg_fifo_sc

Single-clock, show-ahead message FIFO that buffers 32-bit words written by the image-processing block's message writer until the CPU drains them over the memory-mapped port. It reports occupancy (`usedw`) so the producer can throttle message bursts, and supports a synchronous clear for flush requests from the status register.

## Interface
- `DATA_WIDTH`, 32: word width.
- `DEPTH`, 256: number of storage entries, power of two.
- `ADDR_WIDTH`, 8: log2(`DEPTH`); width of pointers and `usedw`.
- `ALMOST_FULL_THRESH`, 252: `almost_full` threshold; used only with `MSG_FIFO_ALMOST_FULL_EN`.

- `clock`: input, 1 bit. The single clock; all state changes on its rising edge.
- `sclr`: input, 1 bit. Reset/clear, synchronous, active-high.
- `data`: input, `DATA_WIDTH` bits. Write data.
- `wrreq`: input, 1 bit. Write request.
- `rdreq`: input, 1 bit. Read (pop) request.
- `q`: output, `DATA_WIDTH` bits. Head word (show-ahead).
- `usedw`: output, `ADDR_WIDTH` bits. Occupancy, modulo `DEPTH`.
- `empty`: output, 1 bit. High when the FIFO holds no words.
- `full`: output, 1 bit. High when the FIFO holds `DEPTH` words.
- `almost_full`: output, 1 bit. Present only with `MSG_FIFO_ALMOST_FULL_EN`.

## Operation
- **Clear.** `sclr` sampled high clears the FIFO: pointers reset to 0, count reset to 0, `empty`=1, `full`=0, `usedw`=0, `q`=0. `sclr` has priority over `wrreq` and `rdreq` in the same cycle. Storage contents are not cleared.
- **Write.** `wrreq` with `full`=0 stores `data` at the write pointer, increments the write pointer (wraps at `DEPTH`) and increments the count.
- **Write when full.** `wrreq` with `full`=1 and `rdreq`=0 is dropped. No state change.
- **Read.** `rdreq` with `empty`=0 pops the head, increments the read pointer (wraps) and decrements the count.
- **Read when empty.** `rdreq` with `empty`=1 is ignored.
- **Simultaneous read and write.**
  - Not empty and not full: both proceed; count unchanged.
  - Empty: only the write takes effect.
  - Full: both proceed; count stays `DEPTH`.
- **Count.** The internal count is `ADDR_WIDTH`+1 bits. `usedw` is its low `ADDR_WIDTH` bits, so `usedw` reads 0 when full. `full` = (count == `DEPTH`); `empty` = (count == 0).
- **Head output.** `q` is the word at the read pointer whenever `empty`=0. `q` is 0 whenever `empty`=1.

## Timing
- All flag and `usedw` updates are visible the cycle after the triggering edge.
- Write into an empty FIFO: `empty` falls and `q` shows the new word one cycle after the `wrreq` edge.
- Pop: `q` shows the next word (or 0 if the FIFO becomes empty) one cycle after the `rdreq` edge.
- A consumer may sample `q` and assert `rdreq` in the same cycle; the value sampled is the popped word.
- Zero bubble: back-to-back `rdreq` on consecutive cycles pops consecutive words.
- Reset mid-operation: one `sclr` cycle fully empties the FIFO regardless of in-flight requests.

## Configuration
- `MSG_FIFO_ALMOST_FULL_EN` defined: port `almost_full` exists and is registered. It is high when count ≥ `ALMOST_FULL_THRESH` and 0 after `sclr`.
- `MSG_FIFO_ALMOST_FULL_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- `msg_fifo_pkg` holds the default `DATA_WIDTH`, `DEPTH`, `ADDR_WIDTH` and `ALMOST_FULL_THRESH` constants, and the message ID constant "RBB" (24'h524242) shared with the producer.
- One sub-module, `msg_fifo_ram`: a simple dual-port memory with a synchronous write port and an asynchronous read port addressed by the read pointer. Pointers, count and flags live in the top level.

## Test plan
- Reset: assert `sclr` one cycle → `empty`=1, `full`=0, `usedw`=0, `q`=0.
- Write 0x00524242 into an empty FIFO → next cycle `empty`=0, `usedw`=1, `q`=0x00524242. Then `rdreq` → `empty`=1, `q`=0.
- Write 256 words 0..255 → `full`=1, `usedw`=0. A 257th write is dropped. Pops return 0..255 in order with no bubbles, then `empty`=1.
- Simultaneous `wrreq` and `rdreq`:
  - Empty: `usedw` becomes 1.
  - Full: `usedw` stays 0, `full` stays 1, and the oldest word is replaced in FIFO order.
  - Half full (count 5): count stays 5.
- `sclr` with `wrreq`=1 while holding 10 words → `empty`=1, `usedw`=0; the write is discarded.
- With `MSG_FIFO_ALMOST_FULL_EN`: write 251 words → `almost_full`=0. The 252nd write → `almost_full`=1 next cycle. One pop → `almost_full`=0.

Source files
------------

// File: rtl/msg_fifo_pkg.sv
// Shared constants for the show-ahead message FIFO.
// The producer uses MSG_ID to tag message words.
package msg_fifo_pkg;

    localparam int MSG_DATA_WIDTH = 32;
    localparam int MSG_DEPTH      = 256;
    localparam int MSG_ADDR_WIDTH = 8;
    localparam int MSG_AF_THRESH  = 252;

    localparam logic [23:0] MSG_ID = 24'h524242;

endpackage

// File: rtl/msg_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// There is no reset, so contents survive a FIFO clear.
module msg_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/msg_fifo_sc.sv
// Single-clock show-ahead message FIFO with occupancy and sync clear.
// Define MSG_FIFO_ALMOST_FULL_EN to add the registered almost_full port.
module msg_fifo_sc
    import msg_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = MSG_DATA_WIDTH,
    parameter int DEPTH      = MSG_DEPTH,
    parameter int ADDR_WIDTH = MSG_ADDR_WIDTH
`ifdef MSG_FIFO_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_THRESH = MSG_AF_THRESH
`endif
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH-1:0] usedw,
    output logic                  empty,
`ifdef MSG_FIFO_ALMOST_FULL_EN
    output logic                  almost_full,
`endif
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  rd_en;

    // A write into a full FIFO proceeds only when a pop frees the slot.
    assign rd_en = rdreq & ~empty;
    assign wr_en = wrreq & (~full | rd_en);

    always_comb begin
        cnt_nxt = cnt;
        unique case ({wr_en, rd_en})
            2'b10:   cnt_nxt = cnt + CNT_ONE;
            2'b01:   cnt_nxt = cnt - CNT_ONE;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == FULL_CNT);
        end
    end

`ifdef MSG_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT =
        (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);

    always_ff @(posedge clock) begin
        if (sclr) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (cnt_nxt >= AF_CNT);
        end
    end
`endif

    msg_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (wr_en & ~sclr),
        .waddr (wr_ptr),
        .wdata (data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign usedw = cnt[ADDR_WIDTH-1:0];
    assign q     = empty ? '0 : rd_data;

endmodule

// File: tb/tb_msg_fifo_sc.sv
// Directed self-checking bench for msg_fifo_sc.
// Define MSG_FIFO_ALMOST_FULL_EN to also exercise almost_full.
module tb_msg_fifo_sc;
    import msg_fifo_pkg::*;

    logic        clock = 1'b0;
    logic        sclr  = 1'b0;
    logic [31:0] data  = '0;
    logic        wrreq = 1'b0;
    logic        rdreq = 1'b0;
    logic [31:0] q;
    logic [7:0]  usedw;
    logic        empty;
    logic        full;
`ifdef MSG_FIFO_ALMOST_FULL_EN
    logic        almost_full;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    msg_fifo_sc dut (
        .clock (clock),
        .sclr  (sclr),
        .data  (data),
        .wrreq (wrreq),
        .rdreq (rdreq),
        .q     (q),
        .usedw (usedw),
        .empty (empty),
`ifdef MSG_FIFO_ALMOST_FULL_EN
        .almost_full (almost_full),
`endif
        .full  (full)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    task automatic write_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            data  = base + 32'(i);
            wrreq = 1'b1;
            tick();
        end
        wrreq = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty got %0b exp 1", empty);
        end
        checks++;
        if (full !== 1'b0) begin
            errors++; $display("FAIL reset_full got %0b exp 0", full);
        end
        checks++;
        if (usedw !== 8'd0) begin
            errors++; $display("FAIL reset_usedw got %0d exp 0", usedw);
        end
        checks++;
        if (q !== 32'd0) begin
            errors++; $display("FAIL reset_q got %0h exp 0", q);
        end
    endtask

    task automatic test_single();
        logic [31:0] id;
        id = {8'h00, MSG_ID};
        do_clear();
        write_n(id, 1);
        checks++;
        if (empty !== 1'b0) begin
            errors++; $display("FAIL single_empty got %0b exp 0", empty);
        end
        checks++;
        if (usedw !== 8'd1) begin
            errors++; $display("FAIL single_usedw got %0d exp 1", usedw);
        end
        checks++;
        if (q !== 32'h00524242) begin
            errors++; $display("FAIL single_q got %0h exp 524242", q);
        end
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL single_pop_empty got %0b exp 1", empty);
        end
        checks++;
        if (q !== 32'd0) begin
            errors++; $display("FAIL single_pop_q got %0h exp 0", q);
        end
    endtask

    task automatic test_fill_drain();
        do_clear();
        write_n(32'd0, 256);
        checks++;
        if (full !== 1'b1 || usedw !== 8'd0) begin
            errors++;
            $display("FAIL fill_flags got full=%0b usedw=%0d exp 1/0",
                     full, usedw);
        end
        write_n(32'hDEAD, 1);
        checks++;
        if (full !== 1'b1 || usedw !== 8'd0 || q !== 32'd0) begin
            errors++;
            $display("FAIL drop_write got full=%0b usedw=%0d q=%0h exp 1/0/0",
                     full, usedw, q);
        end
        rdreq = 1'b1;
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (q !== 32'(i)) begin
                errors++; $display("FAIL drain_q[%0d] got %0h exp %0h", i, q, i);
            end
            tick();
        end
        rdreq = 1'b0;
        checks++;
        if (empty !== 1'b1 || q !== 32'd0) begin
            errors++;
            $display("FAIL drain_empty got empty=%0b q=%0h exp 1/0", empty, q);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp;
        do_clear();
        data  = 32'hA5A5;
        wrreq = 1'b1;
        rdreq = 1'b1;
        tick();
        wrreq = 1'b0;
        rdreq = 1'b0;
        checks++;
        if (usedw !== 8'd1 || q !== 32'hA5A5) begin
            errors++;
            $display("FAIL simul_empty got usedw=%0d q=%0h exp 1/a5a5", usedw, q);
        end

        do_clear();
        write_n(32'd100, 256);
        data  = 32'd7;
        wrreq = 1'b1;
        rdreq = 1'b1;
        tick();
        wrreq = 1'b0;
        checks++;
        if (usedw !== 8'd0 || full !== 1'b1 || q !== 32'd101) begin
            errors++;
            $display("FAIL simul_full got usedw=%0d full=%0b q=%0h exp 0/1/65",
                     usedw, full, q);
        end
        for (int i = 0; i < 256; i++) begin
            exp = (i < 255) ? 32'(101 + i) : 32'd7;
            checks++;
            if (q !== exp) begin
                errors++;
                $display("FAIL simul_full_order[%0d] got %0h exp %0h", i, q, exp);
            end
            tick();
        end
        rdreq = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL simul_full_drain got %0b exp 1", empty);
        end

        do_clear();
        write_n(32'd50, 5);
        data  = 32'd60;
        wrreq = 1'b1;
        rdreq = 1'b1;
        tick();
        wrreq = 1'b0;
        rdreq = 1'b0;
        checks++;
        if (usedw !== 8'd5 || q !== 32'd51) begin
            errors++;
            $display("FAIL simul_half got usedw=%0d q=%0h exp 5/33", usedw, q);
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        write_n(32'd200, 10);
        sclr  = 1'b1;
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = 32'h1234;
        tick();
        sclr  = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        checks++;
        if (empty !== 1'b1 || usedw !== 8'd0 || q !== 32'd0) begin
            errors++;
            $display("FAIL clear_mid got empty=%0b usedw=%0d q=%0h exp 1/0/0",
                     empty, usedw, q);
        end
        tick();
        checks++;
        if (empty !== 1'b1 || usedw !== 8'd0) begin
            errors++;
            $display("FAIL clear_mid_hold got empty=%0b usedw=%0d exp 1/0",
                     empty, usedw);
        end
    endtask

`ifdef MSG_FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        do_clear();
        checks++;
        if (almost_full !== 1'b0) begin
            errors++; $display("FAIL af_reset got %0b exp 0", almost_full);
        end
        write_n(32'd0, 251);
        checks++;
        if (almost_full !== 1'b0) begin
            errors++; $display("FAIL af_251 got %0b exp 0", almost_full);
        end
        write_n(32'd251, 1);
        checks++;
        if (almost_full !== 1'b1) begin
            errors++; $display("FAIL af_252 got %0b exp 1", almost_full);
        end
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        checks++;
        if (almost_full !== 1'b0) begin
            errors++; $display("FAIL af_pop got %0b exp 0", almost_full);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_simultaneous();
        test_clear_mid();
`ifdef MSG_FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
